speck_key_schedule: RTL

Sequential Speck64/128 key expander that sits directly upstream of `speck_round`. It accepts one 128-bit master key and streams the 27 round keys, one per handshake, into the round stage's `k_in` path through a valid/ready interface. Round key i is presented together with its index so the consumer can pair it with round i.

---
 rtl/speck_key_schedule.sv | 113 +++++++++++
 1 files changed

// File: rtl/speck_key_schedule.sv
// Speck64/128 key expander: captures a 128-bit master key and streams the
// round keys k_0..k_{ROUNDS-1}, one per valid/ready handshake, with their index.
module speck_key_schedule #(
    parameter int unsigned W      = 32,
    parameter int unsigned ROUNDS = 27,
    parameter int unsigned ALPHA  = 8,
    parameter int unsigned BETA   = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [4*W-1:0] key_in,
    input  logic           key_valid,
    output logic           key_ready,
    output logic [W-1:0]   rk_out,
    output logic [4:0]     rk_idx,
    output logic           rk_valid,
    input  logic           rk_ready,
    output logic           done
);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    localparam logic [4:0] LastIdx = 5'(ROUNDS - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   k_q, k_d;
    logic [W-1:0]   l0_q, l0_d;
    logic [W-1:0]   l1_q, l1_d;
    logic [W-1:0]   l2_q, l2_d;
    logic [4:0]     idx_q, idx_d;
    logic           done_q, done_d;

    logic [W-1:0]   l0_ror;
    logic [W-1:0]   k_rol;
    logic [W-1:0]   t;

    // Round function datapath: next l word and rotated k for the current index.
    always_comb begin
        l0_ror = (l0_q >> ALPHA) | (l0_q << (W - ALPHA));
        k_rol  = (k_q << BETA) | (k_q >> (W - BETA));
        t      = (k_q + l0_ror) ^ {{(W - 5){1'b0}}, idx_q};
    end

    // Next-state and handshake outputs; key_valid in RUN and rk_ready in IDLE are ignored.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        l0_d      = l0_q;
        l1_d      = l1_q;
        l2_d      = l2_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        key_ready = (state_q == StIdle);
        rk_valid  = (state_q == StRun);

        unique case (state_q)
            StIdle: begin
                if (key_valid) begin
                    k_d     = key_in[W-1:0];
                    l0_d    = key_in[2*W-1:W];
                    l1_d    = key_in[3*W-1:2*W];
                    l2_d    = key_in[4*W-1:3*W];
                    idx_d   = 5'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rk_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        k_d   = k_rol ^ t;
                        l0_d  = l1_q;
                        l1_d  = l2_q;
                        l2_d  = t;
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset clears all key material and returns to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            l0_q    <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign rk_out = k_q;
    assign rk_idx = idx_q;
    assign done   = done_q;

endmodule
